fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address and PC width, legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset, word-aligned.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RES  input  1  asynchronous, active-high reset.
REQ-006 instr_req  output  1  fetch request to instruction memory.
REQ-007 instr_adr  output  XLEN  word address of the current request.
REQ-008 instr_valid  input  1  one-cycle pulse; memory returns the data for instr_adr.
REQ-009 instr_read  input  32  instruction word, qualified by instr_valid.
REQ-010 redirect  input  1  branch/jump taken; flush the queue and refetch.
REQ-011 redirect_adr  input  XLEN  redirect target.
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_instr  output  32  queue-head instruction.
REQ-014 out_pc  output  XLEN  address of out_instr.
REQ-015 out_ready  input  1  consumer accepts the queue head.

Function
REQ-016 States are FETCH, FULL and FLUSH; instr_req is 1 only in FETCH.
REQ-017 Push: instr_req & instr_valid & ~redirect writes {instr_read, instr_adr} at the tail, and fetch PC advances by 4 in the next cycle.
REQ-018 instr_adr shall equal the fetch PC register and shall stay stable while instr_req=1 and no push has occurred.
REQ-019 Pop: out_valid & out_ready & ~redirect removes the head; out_instr/out_pc show the head entry combinationally from storage, with no added latency.
REQ-020 Minimum latency is 1 cycle: an instruction pushed in cycle N is visible on out_valid in cycle N+1.
REQ-021 Occupancy count, range 0..DEPTH: push alone +1, pop alone -1, push and pop together unchanged; out_valid = (count != 0).
REQ-022 FETCH->FULL when the next count equals DEPTH; FULL->FETCH when the next count is below DEPTH; no push occurs while in FULL.
REQ-023 redirect (any state) sets count 0, fetch PC to {redirect_adr[XLEN-1:2], 2'b00} and state FLUSH, and discards any same-cycle instr_valid data and pop.
REQ-024 FLUSH holds instr_req=0 for exactly one cycle, then goes to FETCH; instr_valid arriving in FLUSH is ignored.
REQ-025 A redirect during FLUSH restarts FLUSH with the newest target.
REQ-026 Fetch PC wraps modulo 2^XLEN (all-ones minus 3, plus 4, gives 0).
REQ-027 Queue pointers are log2(DEPTH) bits and wrap naturally; the full/empty decision uses count only.
REQ-028 out_valid=0 shall hold whenever count=0, whatever the out_instr/out_pc values are.

Reset
REQ-029 RES=1 shall asynchronously force state FETCH, count 0, both pointers 0, fetch PC RESET_PC, and therefore out_valid=0, instr_req=1, instr_adr=RESET_PC.
REQ-030 Queue storage is not reset; its contents are don't-care while count=0.
REQ-031 Reset asserted mid-operation overrides a pending push, pop or redirect in that cycle.

Structure
REQ-032 A shared package fetch_pkg shall hold the state enumeration, INSTR_W=32 and the default RESET_PC.
REQ-033 Storage shall be one sub-module, fetch_fifo: DEPTH entries of (32+XLEN) bits, with a synchronous write port and an asynchronous read port, parametrised on DEPTH and width.
REQ-034 The control FSM, counters and fetch PC shall live in fetch_unit.

Verification
REQ-035 Reset release, memory answers every cycle, out_ready=1: instr_adr runs 0x0, 0x4, 0x8 and so on; out_pc trails instr_adr by 1 cycle.
REQ-036 out_ready=0 with DEPTH=4: exactly 4 pushes, then instr_req=0 (FULL); one pop returns instr_req=1 in the next cycle; out_pc stays 0x0 until that pop.
REQ-037 redirect=1, redirect_adr=0x103 in the same cycle as instr_valid: the data is dropped, out_valid=0, one cycle of instr_req=0, then instr_adr=0x100.
REQ-038 count=DEPTH-1, with push and pop in the same cycle: count unchanged, state stays FETCH, order preserved.
REQ-039 XLEN=32, redirect to 0xFFFFFFFC: fetches at 0xFFFFFFFC then 0x00000000.
REQ-040 RES pulsed asynchronously mid-burst with a full queue: out_valid=0 and instr_adr=RESET_PC immediately, with no clock edge needed.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, instruction
// width and the default restart address.
package fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: one synchronous write port, one asynchronous read
// port. Pointers and occupancy are owned by the caller.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [WIDTH-1:0]         rd_data
);

    // Contents are intentionally not reset; the occupancy count qualifies them.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential word fetch into a small prefetch queue,
// with redirect/flush handling and a FETCH/FULL/FLUSH control FSM.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
    input  logic               CLK,
    input  logic               RES,
    output logic               instr_req,
    output logic [XLEN-1:0]    instr_adr,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_read,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_adr,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    input  logic               out_ready
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = INSTR_W + XLEN;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0]  WORD_MASK  = ~(XLEN'(3));

    fetch_state_t     state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign instr_req = (state_reg == ST_FETCH);
    assign instr_adr = pc_reg;
    assign out_valid = (count_reg != '0);

    // A redirect wins over both queue ports in the same cycle.
    assign push = instr_req & instr_valid & ~redirect;
    assign pop  = out_valid & out_ready & ~redirect;

    assign wr_entry  = {instr_read, pc_reg};
    assign out_instr = rd_entry[ENTRY_W-1 -: INSTR_W];
    assign out_pc    = rd_entry[XLEN-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (CLK),
        .wr_en   (push),
        .wr_ptr  (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr_reg),
        .rd_data (rd_entry)
    );

    always_comb begin
        count_next  = count_reg;
        pc_next     = pc_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (redirect) begin
            count_next  = '0;
            pc_next     = redirect_adr & WORD_MASK;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                pc_next     = pc_reg + PC_STEP;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // FULL is decided from the post-update count so a simultaneous pop keeps fetching.
    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = ST_FLUSH;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (count_next == FULL_COUNT) begin
                        state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (count_next < FULL_COUNT) begin
                        state_next = ST_FETCH;
                    end
                end
                ST_FLUSH: state_next = ST_FETCH;
                default:  state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= RESET_PC;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

endmodule
